sharedram_arbiter: RTL

- Arbitrates one single-port 2K x 16 shared RAM between the 68000 (via the decoder's shared-RAM read/write selects) and the sound/protection MCU byte bus.
- Generates the 68000 DTACK for shared-RAM cycles, inserting wait states while the MCU owns the RAM.
- Sits between the 68k address decoder, the MCU bus interface and the RAM macro.

---
 rtl/sharedram_arbiter.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/sharedram_arbiter.sv
// Arbiter for one single-port 2K x 16 shared RAM between the 68000 and the MCU byte bus,
// generating 68k DTACK with wait states. Define SHRAM_STATS_EN to add CONTENTION_CNT.
module sharedram_arbiter #(
    parameter int ADDR_W   = 11,
    parameter bit MCU_PRIO = 1'b0
) (
    input  logic              clk_sys,
    input  logic              nRESET,
    input  logic              nSHAREDRAM_RD,
    input  logic              nSHAREDRAM_WR_U,
    input  logic              nSHAREDRAM_WR_L,
    input  logic [ADDR_W-1:0] M68K_ADDR,
    input  logic [15:0]       M68K_DIN,
    output logic [15:0]       M68K_DOUT,
    output logic              nDTACK_SHR,
    input  logic              MCU_REQ,
    input  logic              MCU_WE,
    input  logic [ADDR_W:0]   MCU_ADDR,
    input  logic [7:0]        MCU_DIN,
    output logic [7:0]        MCU_DOUT,
    output logic              MCU_ACK,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic [15:0]       RAM_WDATA,
    output logic              RAM_WE_U,
    output logic              RAM_WE_L,
    input  logic [15:0]       RAM_RDATA
`ifdef SHRAM_STATS_EN
    ,
    output logic [15:0]       CONTENTION_CNT
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_CAPT, S_CPU_HOLD} state_t;

    state_t              r_state;
    state_t              w_next;
    logic                w_all_hi;
    logic                w_cpu_req;
    logic                w_cpu_wr;
    logic                w_grant_cpu;
    logic                w_grant_mcu;
    logic                r_served;
    logic                r_last_mcu;
    logic                r_owner_mcu;
    logic                r_mcu_wr;
    logic                r_mcu_lo;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [15:0]         r_wdata;
    logic                r_we_u;
    logic                r_we_l;
    logic [15:0]         r_dout;
    logic [7:0]          r_mdout;
    logic                r_dtack_n;
    logic                r_ack;

    assign w_all_hi  = nSHAREDRAM_RD & nSHAREDRAM_WR_U & nSHAREDRAM_WR_L;
    assign w_cpu_req = !w_all_hi && !r_served;
    assign w_cpu_wr  = !nSHAREDRAM_WR_U || !nSHAREDRAM_WR_L;

    // Next-state and grant decision; ties go to whoever was not granted last unless MCU_PRIO
    always_comb begin
        w_next      = r_state;
        w_grant_cpu = 1'b0;
        w_grant_mcu = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cpu_req && MCU_REQ) begin
                    if ((MCU_PRIO == 1'b1) || !r_last_mcu) begin
                        w_grant_mcu = 1'b1;
                    end else begin
                        w_grant_cpu = 1'b1;
                    end
                end else if (w_cpu_req) begin
                    w_grant_cpu = 1'b1;
                end else if (MCU_REQ) begin
                    w_grant_mcu = 1'b1;
                end else begin
                    w_grant_cpu = 1'b0;
                end
                if (w_grant_cpu || w_grant_mcu) begin
                    w_next = S_ACC;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_ACC:      w_next = S_CAPT;
            S_CAPT:     w_next = r_owner_mcu ? S_IDLE : S_CPU_HOLD;
            S_CPU_HOLD: begin
                if (w_all_hi) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_CPU_HOLD;
                end
            end
            default:    w_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_sys) begin
        if (!nRESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Grant bookkeeping, RAM command registers and read-data capture
    always_ff @(posedge clk_sys) begin
        if (!nRESET) begin
            r_served    <= 1'b0;
            r_last_mcu  <= 1'b1;
            r_owner_mcu <= 1'b0;
            r_mcu_wr    <= 1'b0;
            r_mcu_lo    <= 1'b0;
            r_ram_addr  <= {ADDR_W{1'b0}};
            r_wdata     <= 16'h0000;
            r_we_u      <= 1'b0;
            r_we_l      <= 1'b0;
            r_dout      <= 16'h0000;
            r_mdout     <= 8'h00;
            r_dtack_n   <= 1'b1;
            r_ack       <= 1'b0;
        end else begin
            r_we_u <= 1'b0;
            r_we_l <= 1'b0;
            r_ack  <= 1'b0;
            if (w_all_hi) begin
                r_served <= 1'b0;
            end else if (w_grant_cpu) begin
                r_served <= 1'b1;
            end
            if (w_grant_cpu) begin
                r_owner_mcu <= 1'b0;
                r_last_mcu  <= 1'b0;
                r_ram_addr  <= M68K_ADDR;
                if (w_cpu_wr) begin
                    r_wdata <= M68K_DIN;
                    r_we_u  <= !nSHAREDRAM_WR_U;
                    r_we_l  <= !nSHAREDRAM_WR_L;
                end
            end else if (w_grant_mcu) begin
                r_owner_mcu <= 1'b1;
                r_last_mcu  <= 1'b1;
                r_ram_addr  <= MCU_ADDR[ADDR_W:1];
                r_mcu_lo    <= MCU_ADDR[0];
                r_mcu_wr    <= MCU_WE;
                if (MCU_WE) begin
                    r_wdata <= {MCU_DIN, MCU_DIN};
                    r_we_u  <= !MCU_ADDR[0];
                    r_we_l  <= MCU_ADDR[0];
                end
            end
            // RAM_RDATA is valid in CAPT, one cycle after the address was presented
            if (r_state == S_CAPT) begin
                if (!r_owner_mcu) begin
                    r_dout    <= RAM_RDATA;
                    r_dtack_n <= 1'b0;
                end else begin
                    r_ack <= 1'b1;
                    if (!r_mcu_wr) begin
                        r_mdout <= r_mcu_lo ? RAM_RDATA[7:0] : RAM_RDATA[15:8];
                    end
                end
            end else if ((r_state == S_CPU_HOLD) && w_all_hi) begin
                r_dtack_n <= 1'b1;
            end
        end
    end

`ifdef SHRAM_STATS_EN
    logic        w_contend;
    logic [15:0] r_cnt;

    assign w_contend = (r_state != S_IDLE) && (r_owner_mcu ? w_cpu_req : MCU_REQ);

    // Saturating count of cycles in which one side waits on the other's access
    always_ff @(posedge clk_sys) begin
        if (!nRESET) begin
            r_cnt <= 16'h0000;
        end else if (w_contend && (r_cnt != 16'hFFFF)) begin
            r_cnt <= r_cnt + 16'h0001;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign CONTENTION_CNT = r_cnt;
`endif

    assign M68K_DOUT  = r_dout;
    assign nDTACK_SHR = r_dtack_n;
    assign MCU_DOUT   = r_mdout;
    assign MCU_ACK    = r_ack;
    assign RAM_ADDR   = r_ram_addr;
    assign RAM_WDATA  = r_wdata;
    assign RAM_WE_U   = r_we_u;
    assign RAM_WE_L   = r_we_l;

endmodule
